// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and bus widths for the Wishbone word RAM
//
// Purpose: bus width constants and the transfer FSM state type used by
//          wb_word_ram and its RAM sub-module.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADR_W  = 15;
  localparam int WB_SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/ram_bytewise.sv
// rtl/ram_bytewise.sv - single-port synchronous RAM with per-byte write enables
//
// Purpose: storage array of wb_word_ram, kept in its own module so block-RAM
//          inference sees a plain single-port memory with no reset.
// Ports:
//   i_clk    clock, all accesses on the rising edge
//   i_re     read enable; o_rdata is loaded with the addressed word
//   i_we     per-byte write enables, [1] = bits 15:8, [0] = bits 7:0
//   i_addr   word index
//   i_wdata  write data
//   o_rdata  registered read data, holds between reads
module ram_bytewise
  import wb_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_re,
  input  logic [WB_SEL_W-1:0]  i_we,
  input  logic [AW-1:0]        i_addr,
  input  logic [WB_DATA_W-1:0] i_wdata,
  output logic [WB_DATA_W-1:0] o_rdata
);

  logic [WB_DATA_W-1:0] r_mem [DEPTH];
  logic [WB_DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < WB_SEL_W; b++) begin
      if (i_we[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_word_ram.sv
// rtl/wb_word_ram.sv - Wishbone classic slave RAM, 16-bit words, programmable wait states
//
// Purpose: accepts a Wishbone classic request, waits WAIT_STATES cycles, then
//          commits the write / loads read data and pulses ack_o for one cycle.
//          Optional macro WB_RAM_ERR_EN: requests whose address has bits set
//          above the implemented depth terminate with err_o instead of ack_o.
// Ports:
//   clk_i   clock
//   rst_i   asynchronous active-high reset
//   cyc_i   bus cycle valid
//   stb_i   strobe, request valid when cyc_i & stb_i
//   we_i    1 = write, 0 = read
//   sel_i   byte lanes, [1] = dat[15:8], [0] = dat[7:0]
//   adr_i   word address
//   dat_i   write data
//   ack_o   one-cycle transfer acknowledge
//   dat_o   read data, valid during ack_o, held until the next read completes
//   err_o   one-cycle error termination (0 unless WB_RAM_ERR_EN)
module wb_word_ram
  import wb_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [WB_SEL_W-1:0]  sel_i,
  input  logic [WB_ADR_W-1:0]  adr_i,
  input  logic [WB_DATA_W-1:0] dat_i,
  output logic                 ack_o,
  output logic [WB_DATA_W-1:0] dat_o,
  output logic                 err_o
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  wb_state_t r_state, w_next;
  logic [3:0] r_cnt, w_cnt_next;

  logic                 r_we;
  logic [WB_SEL_W-1:0]  r_sel;
  logic [WB_ADR_W-1:0]  r_adr;
  logic [WB_DATA_W-1:0] r_dat;
  logic [WB_DATA_W-1:0] r_dat_o;

  logic                 w_req;
  logic                 w_accept;
  logic                 w_x_we;
  logic [WB_SEL_W-1:0]  w_x_sel;
  logic [WB_ADR_W-1:0]  w_x_adr;
  logic [WB_DATA_W-1:0] w_x_dat;
  logic                 w_x_oor;
  logic                 w_lat_oor;
  logic                 w_enter_ack;
  logic                 w_ram_re;
  logic [WB_SEL_W-1:0]  w_ram_we;
  logic [WB_DATA_W-1:0] w_ram_q;
  logic                 w_rd_done;

  assign w_req    = cyc_i & stb_i;
  assign w_accept = (r_state == IDLE) & w_req;

  // With zero wait states the ACK-entry edge is also the acceptance edge, so
  // the transfer attributes come straight from the bus; otherwise from the
  // values latched at acceptance (later bus changes are ignored).
  assign w_x_we  = (r_state == IDLE) ? we_i  : r_we;
  assign w_x_sel = (r_state == IDLE) ? sel_i : r_sel;
  assign w_x_adr = (r_state == IDLE) ? adr_i : r_adr;
  assign w_x_dat = (r_state == IDLE) ? dat_i : r_dat;

`ifdef WB_RAM_ERR_EN
  assign w_x_oor   = |(w_x_adr >> AW);
  assign w_lat_oor = |(r_adr >> AW);
  assign err_o     = (r_state == ACK) & w_lat_oor;
`else
  // Upper address bits are deliberately ignored so addresses alias.
  logic w_unused_adr_hi;
  assign w_unused_adr_hi = (|(w_x_adr >> AW)) | (|(r_adr >> AW));
  assign w_x_oor   = 1'b0;
  assign w_lat_oor = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (WS == 4'd0) begin
            w_next = ACK;
          end else begin
            w_next     = WAIT;
            w_cnt_next = 4'd1;
          end
        end
      end
      WAIT: begin
        // Abort takes priority over completing the count.
        if (!w_req) begin
          w_next     = IDLE;
          w_cnt_next = 4'd0;
        end else if (r_cnt == WS) begin
          w_next     = ACK;
          w_cnt_next = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      ACK: begin
        w_next = IDLE;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_dat_o <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we  <= we_i;
        r_sel <= sel_i;
        r_adr <= adr_i;
        r_dat <= dat_i;
      end
      if (w_rd_done) begin
        r_dat_o <= w_ram_q;
      end
    end
  end

  // The RAM has no reset, so its enables are gated by rst_i to keep a
  // transfer from committing while reset is held.
  assign w_enter_ack = (w_next == ACK) & ~rst_i & ~w_x_oor;
  assign w_ram_re    = w_enter_ack & ~w_x_we;
  assign w_ram_we    = {WB_SEL_W{w_enter_ack & w_x_we}} & w_x_sel;

  ram_bytewise #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_re    (w_ram_re),
    .i_we    (w_ram_we),
    .i_addr  (w_x_adr[AW-1:0]),
    .i_wdata (w_x_dat),
    .o_rdata (w_ram_q)
  );

  // Read data comes from the RAM output register during the ACK cycle and
  // is captured into r_dat_o so it survives until the next read completes.
  assign w_rd_done = (r_state == ACK) & ~r_we & ~w_lat_oor;
  assign ack_o     = (r_state == ACK) & ~w_lat_oor;
  assign dat_o     = w_rd_done ? w_ram_q : r_dat_o;

endmodule

// File: tb/tb_wb_word_ram.sv
// tb/tb_wb_word_ram.sv - self-checking bench for wb_word_ram (wait states 0, 1 and 3)
module tb_wb_word_ram;

  localparam int DEPTH = 1024;
  localparam int NI    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] cyc;
  logic          stb;
  logic          we;
  logic [1:0]    sel;
  logic [14:0]   adr;
  logic [15:0]   dat;
  logic          ack_w [NI];
  logic          err_w [NI];
  logic [15:0]   dat_w [NI];

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mdl      [NI][DEPTH];
  logic [15:0] mdl_dout [NI];

  always #5 clk = ~clk;

  wb_word_ram #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb), .we_i(we), .sel_i(sel),
    .adr_i(adr), .dat_i(dat), .ack_o(ack_w[0]), .dat_o(dat_w[0]), .err_o(err_w[0]));
  wb_word_ram #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb), .we_i(we), .sel_i(sel),
    .adr_i(adr), .dat_i(dat), .ack_o(ack_w[1]), .dat_o(dat_w[1]), .err_o(err_w[1]));
  wb_word_ram #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb), .we_i(we), .sel_i(sel),
    .adr_i(adr), .dat_i(dat), .ack_o(ack_w[2]), .dat_o(dat_w[2]), .err_o(err_w[2]));

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: word array per instance, index = address modulo DEPTH,
  // out-of-range addresses error out only when the error feature is built in.
  task automatic ref_xfer(input int k, input logic w, input logic [1:0] s, input logic [14:0] a,
                          input logic [15:0] d, output logic e_ack, output logic e_err,
                          output logic [15:0] e_rd);
    int  idx;
    logic oor;
    idx = int'(a) % DEPTH;
`ifdef WB_RAM_ERR_EN
    oor = (int'(a) / DEPTH) != 0;
`else
    oor = 1'b0;
`endif
    e_ack = !oor;
    e_err = oor;
    if (!oor) begin
      if (w) begin
        for (int b = 0; b < 2; b++)
          if (s[b]) mdl[k][idx][b*8 +: 8] = d[b*8 +: 8];
      end else begin
        mdl_dout[k] = mdl[k][idx];
      end
    end
    e_rd = mdl_dout[k];
  endtask

  // Issues one transfer on instance k, scrambles the bus after acceptance,
  // and reports the termination, its edge count and dat_o at that point.
  task automatic xfer(input int k, input logic w, input logic [1:0] s, input logic [14:0] a,
                      input logic [15:0] d, output logic g_ack, output logic g_err,
                      output int lat, output logic [15:0] rd);
    cyc = '0; cyc[k] = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
    g_ack = 1'b0; g_err = 1'b0; lat = 0; rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        we = 1'($urandom); sel = 2'($urandom); adr = 15'($urandom); dat = 16'($urandom);
      end
      if (ack_w[k] || err_w[k]) begin
        g_ack = ack_w[k]; g_err = err_w[k]; lat = n; rd = dat_w[k];
        break;
      end
    end
    stb = 1'b0; cyc = '0;
    @(posedge clk); #1;
    chk("term_one_cycle", {31'd0, ack_w[k] | err_w[k]}, 32'd0);
  endtask

  task automatic run_and_check(input int k, input logic w, input logic [1:0] s,
                               input logic [14:0] a, input logic [15:0] d);
    logic g_ack, g_err, e_ack, e_err;
    int   lat;
    logic [15:0] rd, e_rd;
    xfer(k, w, s, a, d, g_ack, g_err, lat, rd);
    ref_xfer(k, w, s, a, d, e_ack, e_err, e_rd);
    chk("rnd_ack", {31'd0, g_ack}, {31'd0, e_ack});
    chk("rnd_err", {31'd0, g_err}, {31'd0, e_err});
    chk("rnd_latency", lat, ws_of(k) + 1);
    chk("rnd_dat_o", {16'd0, rd}, {16'd0, e_rd});
  endtask

  typedef struct {
    int          k;
    logic        w;
    logic [1:0]  s;
    logic [14:0] a;
    logic [15:0] d;
    logic        e_ack;
    logic        e_err;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tv[10];

  initial begin
    logic g_ack, g_err, x_ack, x_err, seen;
    int   lat;
    logic [15:0] rd, x_rd;

    tv[0] = '{1, 1'b1, 2'b11, 15'h0010, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
    tv[1] = '{1, 1'b0, 2'b00, 15'h0010, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
    tv[2] = '{1, 1'b1, 2'b11, 15'h0020, 16'h1234, 1'b1, 1'b0, 16'hBEEF};
    tv[3] = '{1, 1'b1, 2'b10, 15'h0020, 16'hABCD, 1'b1, 1'b0, 16'hBEEF};
    tv[4] = '{1, 1'b0, 2'b01, 15'h0020, 16'h0000, 1'b1, 1'b0, 16'hAB34};
    tv[5] = '{1, 1'b1, 2'b00, 15'h0020, 16'hFFFF, 1'b1, 1'b0, 16'hAB34};
    tv[6] = '{1, 1'b0, 2'b11, 15'h0020, 16'h0000, 1'b1, 1'b0, 16'hAB34};
`ifdef WB_RAM_ERR_EN
    tv[7] = '{1, 1'b0, 2'b11, 15'h0410, 16'h0000, 1'b0, 1'b1, 16'hAB34};
    tv[8] = '{1, 1'b1, 2'b11, 15'h0410, 16'h0000, 1'b0, 1'b1, 16'hAB34};
    tv[9] = '{1, 1'b0, 2'b11, 15'h0010, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
`else
    tv[7] = '{1, 1'b0, 2'b11, 15'h0410, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
    tv[8] = '{1, 1'b1, 2'b11, 15'h0410, 16'h0000, 1'b1, 1'b0, 16'hBEEF};
    tv[9] = '{1, 1'b0, 2'b11, 15'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000};
`endif

    rst = 1'b1; cyc = '0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0;
    #12;
    for (int k = 0; k < NI; k++) begin
      chk("reset_ack", {31'd0, ack_w[k]}, 32'd0);
      chk("reset_err", {31'd0, err_w[k]}, 32'd0);
      chk("reset_dat_o", {16'd0, dat_w[k]}, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Known contents everywhere so later reads are deterministic.
    for (int k = 0; k < NI; k++) begin
      mdl_dout[k] = '0;
      for (int a = 0; a < DEPTH; a++) begin
        mdl[k][a] = '0;
        xfer(k, 1'b1, 2'b11, 15'(a), 16'h0000, g_ack, g_err, lat, rd);
      end
    end

    // Directed table: basic transfers, byte lanes, aliasing / error range.
    for (int i = 0; i < 10; i++) begin
      xfer(tv[i].k, tv[i].w, tv[i].s, tv[i].a, tv[i].d, g_ack, g_err, lat, rd);
      chk($sformatf("tv%0d_ack", i), {31'd0, g_ack}, {31'd0, tv[i].e_ack});
      chk($sformatf("tv%0d_err", i), {31'd0, g_err}, {31'd0, tv[i].e_err});
      chk($sformatf("tv%0d_latency", i), lat, ws_of(tv[i].k) + 1);
      chk($sformatf("tv%0d_dat_o", i), {16'd0, rd}, {16'd0, tv[i].e_rd});
      ref_xfer(tv[i].k, tv[i].w, tv[i].s, tv[i].a, tv[i].d, x_ack, x_err, x_rd);
    end

    // Continuous strobe with no wait states: ack on alternate cycles.
    cyc = 3'b001; stb = 1'b1; we = 1'b0; sel = 2'b11; adr = 15'h0010;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stream_ack_%0d", i), {31'd0, ack_w[0]}, {31'd0, 1'((i % 2) == 1)});
    end
    stb = 1'b0; cyc = '0;
    @(posedge clk); #1;
    mdl_dout[0] = mdl[0][16];

    // Abort: strobe dropped in the second wait cycle of a 3-wait write.
    cyc = 3'b100; stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 15'h0000; dat = 16'h5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | ack_w[2] | err_w[2];
    end
    cyc = '0;
    chk("abort_no_ack", {31'd0, seen}, 32'd0);
    run_and_check(2, 1'b0, 2'b11, 15'h0000, 16'h0000);

    // Reset during WAIT drops the write; earlier data survives.
    run_and_check(2, 1'b1, 2'b11, 15'h0005, 16'h7777);
    run_and_check(2, 1'b0, 2'b11, 15'h0005, 16'h0000);
    cyc = 3'b100; stb = 1'b1; we = 1'b1; sel = 2'b11; adr = 15'h0005; dat = 16'h1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("rst_wait_ack", {31'd0, ack_w[2]}, 32'd0);
    chk("rst_wait_dat_o", {16'd0, dat_w[2]}, 32'd0);
    stb = 1'b0; cyc = '0;
    #2 rst = 1'b0;
    for (int k = 0; k < NI; k++) mdl_dout[k] = '0;
    @(posedge clk); #1;
    run_and_check(2, 1'b0, 2'b11, 15'h0005, 16'h0000);

    // Reset during ACK: ack falls at once without waiting for an edge.
    cyc = 3'b010; stb = 1'b1; we = 1'b0; sel = 2'b11; adr = 15'h0020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_ack", {31'd0, ack_w[1]}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_ack_ack", {31'd0, ack_w[1]}, 32'd0);
    chk("rst_ack_dat_o", {16'd0, dat_w[1]}, 32'd0);
    stb = 1'b0; cyc = '0;
    #2 rst = 1'b0;
    for (int k = 0; k < NI; k++) mdl_dout[k] = '0;
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      int          k;
      logic [14:0] a;
      k = int'($urandom_range(0, 2));
      a = 15'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) a = a | 15'($urandom_range(1, 31) << 10);
      run_and_check(k, 1'($urandom), 2'($urandom), a, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
